// File: rtl/alien_march_ctrl.sv
// alien_march_ctrl: game-side sequencer for alien_data_ram.
// Marches the formation on step ticks, services kill requests between sweeps
// and reports alive count, wave-clear and invasion events.
module alien_march_ctrl #(
  parameter int unsigned NUM_ALIENS    = 18,
  parameter int unsigned STEP_X        = 4,
  parameter int unsigned STEP_Y        = 8,
  parameter int unsigned X_MIN         = 16,
  parameter int unsigned X_MAX         = 600,
  parameter int unsigned Y_LIMIT       = 400,
  parameter int unsigned EXPLODE_TICKS = 8
) (
  input  logic        game_clk,
  input  logic        reset,
  input  logic        step_tick,
  input  logic        hit_valid,
  input  logic [4:0]  hit_idx,
  output logic        hit_ready,
  output logic        kill_ok,
  output logic [4:0]  game_addr,
  output logic        game_write_en,
  output logic [27:0] game_data_in,
  input  logic [27:0] game_data_out,
  input  logic        write_busy,
  output logic        busy,
  output logic        direction,
  output logic [4:0]  alive_count,
  output logic        sweep_done,
  output logic        wave_clear,
  output logic        invaded
);

  localparam int unsigned IDX_W   = 5;
  localparam int unsigned REC_W   = 28;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned SUM_W   = COORD_W + 1;
  localparam int unsigned TMR_W   = 5;
  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ISSUE,
    WR_WAIT,
    NEXT,
    DONE
  } state_t;

  state_t             state, state_d;
  logic               kill_mode, kill_mode_d;
  logic [IDX_W-1:0]   idx, idx_d;
  logic               tick_pending, tick_pending_d;
  logic               drop_pending, drop_pending_d;
  logic               edge_acc, edge_acc_d;
  logic               invade_acc, invade_acc_d;
  logic [IDX_W-1:0]   alive_acc, alive_acc_d;
  logic               seen_busy, seen_busy_d;

  logic               hit_ready_d, kill_ok_d, game_write_en_d, busy_d, direction_d;
  logic               sweep_done_d, wave_clear_d, invaded_d;
  logic [IDX_W-1:0]   game_addr_d, alive_count_d;
  logic [REC_W-1:0]   game_data_in_d;

  logic [COORD_W-1:0] rec_x, rec_y, x_right, x_left, x_new, y_new;
  logic [SUM_W-1:0]   x_sum, y_sum;
  logic [TMR_W-1:0]   rec_timer;
  logic               rec_alive, at_edge, at_limit;

  // Decode the record just read and compute its marched position.
  always_comb begin
    rec_x     = game_data_out[27:18];
    rec_y     = game_data_out[17:8];
    rec_alive = game_data_out[5];
    rec_timer = game_data_out[4:0];
    x_sum     = SUM_W'(rec_x) + SUM_W'(STEP_X);
    y_sum     = SUM_W'(rec_y) + SUM_W'(STEP_Y);
    x_right   = (x_sum > SUM_W'(COORD_MAX)) ? COORD_MAX : x_sum[COORD_W-1:0];
    x_left    = (rec_x < COORD_W'(STEP_X)) ? '0 : rec_x - COORD_W'(STEP_X);
    if (drop_pending) begin
      x_new = rec_x;
      y_new = (y_sum > SUM_W'(COORD_MAX)) ? COORD_MAX : y_sum[COORD_W-1:0];
    end else begin
      x_new = direction ? x_right : x_left;
      y_new = rec_y;
    end
    at_edge  = !drop_pending &&
               ((x_new <= COORD_W'(X_MIN)) || (x_new >= COORD_W'(X_MAX)));
    at_limit = (y_new >= COORD_W'(Y_LIMIT));
  end

  // Next-state and next-output logic for sweeps and kills.
  always_comb begin
    state_d         = state;
    kill_mode_d     = kill_mode;
    idx_d           = idx;
    tick_pending_d  = tick_pending | step_tick;
    drop_pending_d  = drop_pending;
    edge_acc_d      = edge_acc;
    invade_acc_d    = invade_acc;
    alive_acc_d     = alive_acc;
    seen_busy_d     = seen_busy;
    hit_ready_d     = 1'b0;
    kill_ok_d       = 1'b0;
    game_write_en_d = 1'b0;
    game_addr_d     = game_addr;
    game_data_in_d  = game_data_in;
    direction_d     = direction;
    alive_count_d   = alive_count;
    sweep_done_d    = 1'b0;
    wave_clear_d    = 1'b0;
    invaded_d       = 1'b0;

    case (state)
      IDLE: begin
        // hit_ready is still high the cycle after a kill; don't re-accept it
        if (hit_valid && !hit_ready) begin
          kill_mode_d = 1'b1;
          idx_d       = hit_idx;
          game_addr_d = hit_idx;
          state_d     = RD_ADDR;
        end else if (tick_pending) begin
          kill_mode_d    = 1'b0;
          idx_d          = '0;
          game_addr_d    = '0;
          tick_pending_d = step_tick;
          state_d        = RD_ADDR;
        end
      end

      RD_ADDR: state_d = RD_DATA;

      RD_DATA: begin
        if (!write_busy) begin
          if (kill_mode) begin
            if ((idx < IDX_W'(NUM_ALIENS)) && rec_alive) begin
              game_data_in_d  = {game_data_out[27:6], 1'b0, TMR_W'(EXPLODE_TICKS)};
              game_write_en_d = 1'b1;
              state_d         = WR_ISSUE;
            end else begin
              hit_ready_d = 1'b1;
              state_d     = IDLE;
            end
          end else if (rec_alive) begin
            game_data_in_d  = {x_new, y_new, game_data_out[7:0]};
            alive_acc_d     = alive_acc + IDX_W'(1);
            edge_acc_d      = edge_acc | at_edge;
            invade_acc_d    = invade_acc | at_limit;
            game_write_en_d = 1'b1;
            state_d         = WR_ISSUE;
          end else if (rec_timer != '0) begin
            game_data_in_d  = {game_data_out[27:5], rec_timer - TMR_W'(1)};
            game_write_en_d = 1'b1;
            state_d         = WR_ISSUE;
          end else begin
            state_d = NEXT;
          end
        end
      end

      WR_ISSUE: begin
        seen_busy_d = write_busy;
        state_d     = WR_WAIT;
      end

      WR_WAIT: begin
        if (write_busy) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy) begin
          seen_busy_d = 1'b0;
          if (kill_mode) begin
            hit_ready_d   = 1'b1;
            kill_ok_d     = 1'b1;
            alive_count_d = (alive_count == '0) ? '0 : alive_count - IDX_W'(1);
            state_d       = IDLE;
          end else begin
            state_d = NEXT;
          end
        end
      end

      NEXT: begin
        if (idx == IDX_W'(NUM_ALIENS - 1)) begin
          state_d = DONE;
        end else begin
          idx_d       = idx + IDX_W'(1);
          game_addr_d = idx + IDX_W'(1);
          state_d     = RD_ADDR;
        end
      end

      DONE: begin
        alive_count_d = alive_acc;
        sweep_done_d  = 1'b1;
        wave_clear_d  = (alive_acc == '0);
        invaded_d     = invade_acc;
        if (drop_pending) begin
          direction_d    = !direction;
          drop_pending_d = 1'b0;
        end else begin
          drop_pending_d = edge_acc;
        end
        alive_acc_d  = '0;
        edge_acc_d   = 1'b0;
        invade_acc_d = 1'b0;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; synchronous reset aborts any operation.
  always_ff @(posedge game_clk) begin
    if (reset) begin
      state         <= IDLE;
      kill_mode     <= 1'b0;
      idx           <= '0;
      tick_pending  <= 1'b0;
      drop_pending  <= 1'b0;
      edge_acc      <= 1'b0;
      invade_acc    <= 1'b0;
      alive_acc     <= '0;
      seen_busy     <= 1'b0;
      hit_ready     <= 1'b0;
      kill_ok       <= 1'b0;
      game_addr     <= '0;
      game_write_en <= 1'b0;
      game_data_in  <= '0;
      busy          <= 1'b0;
      direction     <= 1'b1;
      alive_count   <= IDX_W'(NUM_ALIENS);
      sweep_done    <= 1'b0;
      wave_clear    <= 1'b0;
      invaded       <= 1'b0;
    end else begin
      state         <= state_d;
      kill_mode     <= kill_mode_d;
      idx           <= idx_d;
      tick_pending  <= tick_pending_d;
      drop_pending  <= drop_pending_d;
      edge_acc      <= edge_acc_d;
      invade_acc    <= invade_acc_d;
      alive_acc     <= alive_acc_d;
      seen_busy     <= seen_busy_d;
      hit_ready     <= hit_ready_d;
      kill_ok       <= kill_ok_d;
      game_addr     <= game_addr_d;
      game_write_en <= game_write_en_d;
      game_data_in  <= game_data_in_d;
      busy          <= busy_d;
      direction     <= direction_d;
      alive_count   <= alive_count_d;
      sweep_done    <= sweep_done_d;
      wave_clear    <= wave_clear_d;
      invaded       <= invaded_d;
    end
  end

endmodule

// File: tb/tb_alien_march_ctrl.sv
// Bench for alien_march_ctrl: RAM model with variable write latency and a
// reference model feeding expected writes and sweep results into queues.
module tb_alien_march_ctrl;

  localparam int unsigned N   = 18;
  localparam int unsigned TMO = 3000;

  typedef struct packed { logic [4:0] a; logic [27:0] d; } wr_t;
  typedef struct packed { logic [4:0] alive; logic wave; logic inv; logic dir; } res_t;

  logic        game_clk = 1'b0;
  logic        reset = 1'b1;
  logic        step_tick = 1'b0;
  logic        hit_valid = 1'b0;
  logic [4:0]  hit_idx = '0;
  logic        hit_ready, kill_ok, game_write_en, busy, direction;
  logic        sweep_done, wave_clear, invaded;
  logic [4:0]  game_addr, alive_count;
  logic [27:0] game_data_in, game_data_out;
  logic        write_busy;

  alien_march_ctrl dut (
    .game_clk      (game_clk),
    .reset         (reset),
    .step_tick     (step_tick),
    .hit_valid     (hit_valid),
    .hit_idx       (hit_idx),
    .hit_ready     (hit_ready),
    .kill_ok       (kill_ok),
    .game_addr     (game_addr),
    .game_write_en (game_write_en),
    .game_data_in  (game_data_in),
    .game_data_out (game_data_out),
    .write_busy    (write_busy),
    .busy          (busy),
    .direction     (direction),
    .alive_count   (alive_count),
    .sweep_done    (sweep_done),
    .wave_clear    (wave_clear),
    .invaded       (invaded)
  );

  always #5 game_clk = ~game_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Initial alien layout: kind 0 = standard formation, kind 1 = one alien on the invade line
  function automatic logic [27:0] init_rec(int i, int kind);
    logic [9:0] x, y;
    logic [1:0] t;
    if (i >= N) return 28'd0;
    if (kind == 0) begin
      x = 10'(50 + 40 * (i % 6));
      y = 10'(50 + 35 * (i / 6));
      t = 2'(i / 6);
      return {x, y, t, 1'b1, 5'd0};
    end
    if (i == 0) return {10'd300, 10'd400, 2'd0, 1'b1, 5'd0};
    return {10'd100, 10'd100, 2'd1, 1'b0, 5'd0};
  endfunction

  // RAM model: registered read, write_busy for busy_len cycles, hold/overlap monitors
  logic [27:0] mem [32];
  int          busy_len = 1;
  int          busy_cnt = 0;
  logic [4:0]  lat_addr;
  logic [27:0] lat_data;
  wr_t         act_buf [4096];
  int          act_n = 0;
  int          wr_count [32];
  int          hold_viol = 0;
  int          busy_viol = 0;
  logic        load_req = 1'b0;
  int          load_kind = 0;

  always @(posedge game_clk) begin
    if (load_req)
      for (int i = 0; i < 32; i++) mem[i] <= init_rec(i, load_kind);
    if (reset) begin
      write_busy <= 1'b0;
      busy_cnt   <= 0;
    end else begin
      if (write_busy === 1'b1) begin
        if (game_addr !== lat_addr || game_data_in !== lat_data) hold_viol <= hold_viol + 1;
        if (busy_cnt == 1) begin
          mem[lat_addr] <= lat_data;
          write_busy    <= 1'b0;
        end
        busy_cnt <= busy_cnt - 1;
      end
      if (game_write_en === 1'b1) begin
        if (write_busy === 1'b1) busy_viol <= busy_viol + 1;
        if (act_n < 4096) act_buf[act_n] <= {game_addr, game_data_in};
        act_n              <= act_n + 1;
        wr_count[game_addr] <= wr_count[game_addr] + 1;
        lat_addr           <= game_addr;
        lat_data           <= game_data_in;
        write_busy         <= 1'b1;
        busy_cnt           <= busy_len;
      end
    end
    game_data_out <= mem[game_addr];
  end

  // Reference model state
  logic [27:0] ref_mem [32];
  logic        ref_dir = 1'b1;
  logic        ref_drop = 1'b0;
  int          ref_alive_cnt = N;
  wr_t         exp_q [$];
  res_t        res_q [$];
  int          rd_ptr = 0;
  int          last_push = 0;

  task automatic model_sweep();
    logic [27:0] r;
    int x, y, cnt;
    bit edge_f, inv_f;
    wr_t w;
    res_t rs;
    cnt = 0; edge_f = 0; inv_f = 0; last_push = 0;
    for (int i = 0; i < N; i++) begin
      r = ref_mem[i];
      x = int'(r[27:18]);
      y = int'(r[17:8]);
      if (r[5]) begin
        if (ref_drop) begin
          y = (y + 8 > 1023) ? 1023 : y + 8;
        end else begin
          if (ref_dir) x = (x + 4 > 1023) ? 1023 : x + 4;
          else         x = (x < 4) ? 0 : x - 4;
          if (x <= 16 || x >= 600) edge_f = 1;
        end
        if (y >= 400) inv_f = 1;
        cnt++;
        w.a = 5'(i);
        w.d = {10'(x), 10'(y), r[7:0]};
      end else if (r[4:0] != 5'd0) begin
        w.a = 5'(i);
        w.d = {r[27:5], r[4:0] - 5'd1};
      end else begin
        continue;
      end
      ref_mem[i] = w.d;
      exp_q.push_back(w);
      last_push++;
    end
    if (ref_drop) begin
      ref_dir  = !ref_dir;
      ref_drop = 1'b0;
    end else begin
      ref_drop = edge_f;
    end
    ref_alive_cnt = cnt;
    rs.alive = 5'(cnt);
    rs.wave  = (cnt == 0);
    rs.inv   = inv_f;
    rs.dir   = ref_dir;
    res_q.push_back(rs);
  endtask

  task automatic apply_reset();
    @(negedge game_clk);
    reset = 1'b1; step_tick = 1'b0; hit_valid = 1'b0;
    repeat (2) @(negedge game_clk);
    reset = 1'b0;
    ref_dir = 1'b1; ref_drop = 1'b0; ref_alive_cnt = N;
    exp_q.delete(); res_q.delete();
    rd_ptr = act_n;
  endtask

  task automatic load_mem(int kind);
    @(negedge game_clk);
    load_kind = kind; load_req = 1'b1;
    @(negedge game_clk);
    load_req = 1'b0;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_rec(i, kind);
  endtask

  task automatic tick();
    model_sweep();
    @(negedge game_clk);
    step_tick = 1'b1;
    @(negedge game_clk);
    step_tick = 1'b0;
  endtask

  // Waits for a sweep_done and scores the sweep result and all writes seen so far
  task automatic wait_sweep(string name, int exp_left);
    bit seen;
    res_t r;
    wr_t e, a;
    seen = 0;
    for (int cyc = 0; cyc < TMO && !seen; cyc++) begin
      @(negedge game_clk);
      if (sweep_done === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: sweep_done never seen within %0d cycles", name, TMO);
    end else begin
      r = res_q.pop_front();
      n_checks++;
      if ({alive_count, wave_clear, invaded, direction} !== {r.alive, r.wave, r.inv, r.dir}) begin
        n_fail++;
        $display("FAIL %s: alive/wave/inv/dir got %0d/%b/%b/%b expected %0d/%b/%b/%b", name,
                 alive_count, wave_clear, invaded, direction, r.alive, r.wave, r.inv, r.dir);
      end
    end
    while (rd_ptr < act_n) begin
      a = act_buf[rd_ptr];
      rd_ptr++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: unexpected write addr %0d data %h", name, a.a, a.d);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: write got addr %0d data %h expected addr %0d data %h",
                   name, a.a, a.d, e.a, e.d);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != exp_left) begin
      n_fail++;
      $display("FAIL %s: %0d expected writes outstanding, expected %0d", name, exp_q.size(), exp_left);
    end
  endtask

  task automatic do_kill(int idx, string name);
    bit exp_ok, seen;
    wr_t w, a, e;
    exp_ok = 0;
    if (idx < N && ref_mem[idx][5]) begin
      w.a = 5'(idx);
      w.d = {ref_mem[idx][27:6], 1'b0, 5'd8};
      ref_mem[idx] = w.d;
      exp_q.push_back(w);
      exp_ok = 1;
      if (ref_alive_cnt > 0) ref_alive_cnt--;
    end
    @(negedge game_clk);
    hit_valid = 1'b1; hit_idx = 5'(idx);
    seen = 0;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      @(negedge game_clk);
      if (hit_ready === 1'b1) seen = 1;
    end
    hit_valid = 1'b0;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: hit_ready never seen", name);
    end else begin
      n_checks++;
      if (kill_ok !== exp_ok || alive_count !== 5'(ref_alive_cnt)) begin
        n_fail++;
        $display("FAIL %s: kill_ok/alive_count got %b/%0d expected %b/%0d", name,
                 kill_ok, alive_count, exp_ok, ref_alive_cnt);
      end
    end
    while (rd_ptr < act_n) begin
      a = act_buf[rd_ptr];
      rd_ptr++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s: unexpected write addr %0d data %h", name, a.a, a.d);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL %s: write got %0d/%h expected %0d/%h", name, a.a, a.d, e.a, e.d);
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: kill write missing", name);
    end
    @(negedge game_clk);
    n_checks++;
    if (hit_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: hit_ready got %b expected 0 one cycle later", name, hit_ready);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({hit_ready, kill_ok, game_write_en, busy, sweep_done, wave_clear, invaded} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b expected 0000000",
               {hit_ready, kill_ok, game_write_en, busy, sweep_done, wave_clear, invaded});
    end
    n_checks++;
    if (game_addr !== 5'd0 || game_data_in !== 28'd0) begin
      n_fail++;
      $display("FAIL reset_bus: addr %0d data %h expected 0/0", game_addr, game_data_in);
    end
    n_checks++;
    if (direction !== 1'b1 || alive_count !== 5'd18) begin
      n_fail++;
      $display("FAIL reset_state: dir %b alive %0d expected 1/18", direction, alive_count);
    end
    load_mem(0);
  endtask

  task automatic test_first_sweep();
    int start;
    start = act_n;
    tick();
    wait_sweep("first_sweep", 0);
    n_checks++;
    if (mem[0] !== {10'd54, 10'd50, 2'd0, 1'b1, 5'd0}) begin
      n_fail++;
      $display("FAIL first_alien0: got %h expected %h", mem[0], {10'd54, 10'd50, 2'd0, 1'b1, 5'd0});
    end
    n_checks++;
    if (mem[17] !== {10'd254, 10'd120, 2'd2, 1'b1, 5'd0}) begin
      n_fail++;
      $display("FAIL first_alien17: got %h expected %h", mem[17], {10'd254, 10'd120, 2'd2, 1'b1, 5'd0});
    end
    n_checks++;
    if (act_n - start != 18) begin
      n_fail++;
      $display("FAIL first_writes: got %0d writes expected 18", act_n - start);
    end
  endtask

  task automatic test_march_edge();
    logic [9:0] x0, y0;
    for (int t = 2; t <= 88; t++) begin
      tick();
      wait_sweep("march", 0);
    end
    n_checks++;
    if (mem[5][27:18] !== 10'd602 || direction !== 1'b1) begin
      n_fail++;
      $display("FAIL edge_reach: x5 %0d dir %b expected 602/1", mem[5][27:18], direction);
    end
    x0 = mem[0][27:18];
    y0 = mem[0][17:8];
    tick();
    wait_sweep("drop", 0);
    n_checks++;
    if (mem[0][27:18] !== x0 || mem[0][17:8] !== y0 + 10'd8 || direction !== 1'b0) begin
      n_fail++;
      $display("FAIL drop: x %0d y %0d dir %b expected %0d/%0d/0", mem[0][27:18], mem[0][17:8],
               direction, x0, y0 + 10'd8);
    end
    tick();
    wait_sweep("reverse", 0);
    n_checks++;
    if (mem[0][27:18] !== x0 - 10'd4) begin
      n_fail++;
      $display("FAIL reverse: x %0d expected %0d", mem[0][27:18], x0 - 10'd4);
    end
  endtask

  task automatic test_kill();
    int c0, start;
    do_kill(3, "kill3");
    n_checks++;
    if (mem[3][5:0] !== 6'b0_01000) begin
      n_fail++;
      $display("FAIL kill3_rec: alive/timer got %b expected 001000", mem[3][5:0]);
    end
    c0 = wr_count[3];
    for (int s = 0; s < 8; s++) begin
      tick();
      wait_sweep("timer", 0);
    end
    n_checks++;
    if (wr_count[3] - c0 != 8 || mem[3][4:0] !== 5'd0) begin
      n_fail++;
      $display("FAIL timer_run: writes %0d timer %0d expected 8/0", wr_count[3] - c0, mem[3][4:0]);
    end
    start = act_n;
    tick();
    wait_sweep("timer_idle", 0);
    n_checks++;
    if (wr_count[3] - c0 != 8 || act_n - start != 17) begin
      n_fail++;
      $display("FAIL timer_idle: idx3 writes %0d sweep writes %0d expected 8/17",
               wr_count[3] - c0, act_n - start);
    end
  endtask

  task automatic test_back_to_back();
    bit seen, early;
    int exp_cnt;
    wr_t w;
    w.a = 5'd4;
    w.d = {ref_mem[4][27:6], 1'b0, 5'd8};
    ref_mem[4] = w.d;
    exp_q.push_back(w);
    exp_cnt = ref_alive_cnt - 1;
    model_sweep();
    @(negedge game_clk);
    hit_valid = 1'b1; hit_idx = 5'd4; step_tick = 1'b1;
    @(negedge game_clk);
    step_tick = 1'b0;
    seen = 0; early = 0;
    if (hit_ready === 1'b1) seen = 1;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      @(negedge game_clk);
      if (sweep_done === 1'b1) early = 1;
      if (hit_ready === 1'b1) seen = 1;
    end
    hit_valid = 1'b0;
    n_checks++;
    if (!seen || early) begin
      n_fail++;
      $display("FAIL b2b_order: hit_ready seen %b sweep_done before it %b expected 1/0", seen, early);
    end
    n_checks++;
    if (kill_ok !== 1'b1 || alive_count !== 5'(exp_cnt)) begin
      n_fail++;
      $display("FAIL b2b_kill: kill_ok %b alive %0d expected 1/%0d", kill_ok, alive_count, exp_cnt);
    end
    repeat (10) @(negedge game_clk);
    tick();
    wait_sweep("b2b_sweep1", last_push);
    wait_sweep("b2b_sweep2", 0);
    seen = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge game_clk);
      if (sweep_done === 1'b1 || busy === 1'b1) seen = 1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL b2b_extra: extra sweep activity got 1 expected 0");
    end
  endtask

  task automatic test_wave_clear();
    for (int i = 0; i < N; i++) do_kill(i, "kill_all");
    do_kill(20, "kill_oob");
    n_checks++;
    if (alive_count !== 5'd0) begin
      n_fail++;
      $display("FAIL all_dead: alive_count %0d expected 0", alive_count);
    end
    tick();
    wait_sweep("wave_clear", 0);
    tick();
    wait_sweep("wave_clear2", 0);
  endtask

  task automatic test_invade();
    apply_reset();
    load_mem(1);
    tick();
    wait_sweep("invade", 0);
  endtask

  task automatic test_stall_reset();
    bit seen, extra;
    busy_len = 6;
    tick();
    seen = 0;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      @(negedge game_clk);
      if (game_write_en === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL stall_write: game_write_en never seen");
    end
    extra = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge game_clk);
      if (game_write_en !== 1'b0) extra = 1;
    end
    n_checks++;
    if (extra) begin
      n_fail++;
      $display("FAIL stall_second_write: write_en during busy got 1 expected 0");
    end
    reset = 1'b1;
    @(negedge game_clk);
    n_checks++;
    if ({game_write_en, busy, hit_ready, sweep_done, direction} !== 5'b00001 || alive_count !== 5'd18) begin
      n_fail++;
      $display("FAIL midwrite_reset: we/busy/hr/sd/dir %b alive %0d expected 00001/18",
               {game_write_en, busy, hit_ready, sweep_done, direction}, alive_count);
    end
    n_checks++;
    if (hold_viol != 0 || busy_viol != 0) begin
      n_fail++;
      $display("FAIL write_hold: hold violations %0d overlap writes %0d expected 0/0", hold_viol, busy_viol);
    end
    busy_len = 1;
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_first_sweep();
    test_march_edge();
    test_kill();
    test_back_to_back();
    test_wave_clear();
    test_invade();
    test_stall_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alien_march_ctrl.md
Name: alien_march_ctrl

Overview:
- Sequencer that owns the game-side port of alien_data_ram (game_clk domain).
- On each step tick it sweeps all alien records: marches the formation horizontally, drops it and reverses at the screen edge, and counts down explosion timers.
- Between sweeps it services kill requests from collision logic. It reports alive count, wave-clear and invasion events to the game FSM.

Parameters:
NUM_ALIENS, 18, number of records swept (addresses 0..NUM_ALIENS-1)
STEP_X, 4, horizontal pixels per march step
STEP_Y, 8, vertical pixels per drop step
X_MIN, 16, left edge; an alive alien with new x <= X_MIN flags an edge
X_MAX, 600, right edge; an alive alien with new x >= X_MAX flags an edge
Y_LIMIT, 400, an alive alien with new y >= Y_LIMIT raises invaded
EXPLODE_TICKS, 8, timer value loaded on kill (5-bit)

Ports:
game_clk  in  1  system game clock
reset  in  1  synchronous, active-high
step_tick  in  1  one-cycle pulse requesting a march sweep
hit_valid  in  1  kill request, held until hit_ready
hit_idx  in  5  alien index to kill
hit_ready  out  1  one-cycle pulse: kill request accepted and completed
kill_ok  out  1  pulses with hit_ready when the target was alive
game_addr  out  5  RAM address (registered)
game_write_en  out  1  RAM write strobe (one cycle)
game_data_in  out  28  RAM write data
game_data_out  in  28  RAM read data (one-cycle registered latency)
write_busy  in  1  RAM write in progress
busy  out  1  high whenever state != IDLE
direction  out  1  1 = moving right, 0 = moving left
alive_count  out  5  alive aliens counted in the last sweep
sweep_done  out  1  one-cycle pulse at end of each sweep
wave_clear  out  1  pulses with sweep_done when alive_count result is 0
invaded  out  1  one-cycle pulse at sweep end if any alive alien reached Y_LIMIT

Behaviour:
- Record format: x[27:18], y[17:8], type[7:6], alive[5], timer[4:0].
- Reset:
  - All outputs 0 except direction = 1 and alive_count = NUM_ALIENS.
  - drop_pending = 0, tick_pending = 0, state = IDLE.
  - Reset mid-operation aborts immediately; game_write_en is low the cycle after reset.
- States: IDLE, RD_ADDR, RD_DATA, WR_ISSUE, WR_WAIT, NEXT, DONE. The kill path reuses RD_ADDR..WR_WAIT with a kill_mode flag.
- Scheduling:
  - A step_tick arriving in any state sets tick_pending. Multiple ticks during one sweep collapse into one.
  - In IDLE, a held hit_valid has priority over tick_pending.
  - A sweep is never interrupted. A kill waits until DONE returns to IDLE.
- Read:
  - game_addr is loaded on entry to RD_ADDR.
  - RD_DATA captures game_data_out, giving 2 cycles per read.
- Write handshake:
  - WR_ISSUE asserts game_write_en for exactly one cycle.
  - WR_WAIT holds game_addr and game_data_in stable until write_busy has been seen high and then low. Only then does the FSM proceed.
  - game_write_en is never asserted while write_busy = 1.
- Sweep update, alien alive:
  - If drop_pending: y_new = min(y + STEP_Y, 1023) and x is unchanged.
  - Otherwise x_new = x ± STEP_X, clamped to 0..1023.
  - Edge flag set per the X_MIN/X_MAX rules, evaluated on x_new and only when not dropping.
  - Invade flag set if y_new >= Y_LIMIT.
  - alive_acc increments.
- Sweep update, alien dead:
  - If timer != 0, timer decrements by 1.
  - If timer == 0, the record is unchanged and the write is skipped (RD_DATA goes straight to NEXT).
- NEXT: the index increments. Past NUM_ALIENS-1 it goes to DONE.
- DONE:
  - alive_count <= alive_acc; sweep_done pulses; wave_clear and invaded pulse per their flags.
  - If the sweep was a drop sweep: direction toggles and drop_pending clears.
  - Otherwise drop_pending <= edge flag.
  - Accumulators clear.
- Kill:
  - Read hit_idx.
  - If alive: write alive = 0, timer = EXPLODE_TICKS; pulse hit_ready and kill_ok after WR_WAIT completes.
  - If dead, or hit_idx >= NUM_ALIENS: no write; pulse hit_ready only.
  - alive_count decrements immediately on kill_ok, saturating at 0.

Test Plan:
- Reset, one step_tick, direction = 1 → alien 0 rewritten (50,50) → (54,50); alien 17 → (254,120); sweep_done after 18 writes; alive_count = 18.
- 88 ticks → alien 5 x = 602 ≥ 600; after tick 89: every y += 8, x unchanged, direction = 0; tick 90 → alien 0 x decreases by 4.
- hit_valid with hit_idx = 3 while idle → one write with alive = 0, timer = 8; hit_ready and kill_ok pulse; alive_count = 17; the next 8 sweeps decrement the timer to 0; the 9th sweep does no write for index 3.
- hit_valid and step_tick in the same idle cycle → kill completes first, then the sweep runs; a second step_tick during the sweep runs exactly one more sweep.
- Kill all 18 aliens, then one tick → sweep_done with wave_clear, alive_count = 0, zero edge/invade effects.
- Write_busy held high 5 extra cycles → game_addr and game_data_in stable throughout; no second write_en; reset asserted mid-WR_WAIT → state IDLE, outputs at reset values next cycle.
